bad_point_lut_writer: RTL and testbench
=======================================

# bad_point_lut_writer

Writer side of the bad-pixel lookup table. Accepts bad-pixel coordinates from the on-line detector during a frame, filters them into strict raster order, writes them as packed entries into the dual-port bad-point BRAM write port, and publishes the committed entry count at frame end for the correction-side table reader.

## Interface
Parameters:
- WIDTH_BITS, 10, x coordinate width
- HEIGHT_BITS, 10, y coordinate width
- BAD_POINT_NUM, 128, BRAM depth; usable capacity CAP = BAD_POINT_NUM-1
- BAD_POINT_BIT, 7, address/count width; BAD_POINT_NUM must be ≤ 2^BAD_POINT_BIT

Ports:
- clk  in  1  clock; also drives LUT write port
- rst_n  in  1  reset, asynchronous, active-low
- frame_start  in  1  level/pulse; rising edge starts a collection
- frame_end  in  1  single-cycle pulse; ends the collection
- det_valid  in  1  detector coordinate valid
- det_ready  out  1  writer accepts coordinate
- det_x  in  WIDTH_BITS  detected x
- det_y  in  HEIGHT_BITS  detected y
- wen_lut  out  1  LUT write enable
- waddr_lut  out  BAD_POINT_BIT (+1 with macro)  LUT write address
- wdata_lut  out  32  {16'(y), 16'(x)}, zero-extended
- bad_point_num  out  BAD_POINT_BIT  committed entry count for the reader
- busy  out  1  collection in progress
- overflow  out  1  sticky per frame: entry dropped because CAP reached
- order_err  out  1  sticky per frame: entry dropped as duplicate/out-of-order

## Operation
- States: IDLE, COLLECT, COMMIT.
- IDLE: det_ready=0. frame_start rising edge → COLLECT; count←0, overflow←0, order_err←0, last-key valid←0.
- COLLECT: det_ready=1. Handshake = det_valid & det_ready. Key = {det_y, det_x}.
  - Key ≤ last key (last valid): drop, order_err←1.
  - count == CAP: drop, overflow←1.
  - Otherwise: write entry at address count, count←count+1, last key←key.
- frame_end in COLLECT → COMMIT; handshake in that same cycle is still processed and counted.
- COMMIT (one cycle): bad_point_num←count; → IDLE.
- frame_start rising edge in COLLECT or COMMIT: restart collection (count, flags cleared, no commit). frame_start edge and frame_end in the same cycle: frame_start wins.
- frame_end outside COLLECT: ignored.

## Timing
- Reset: state IDLE; all outputs 0; edge-detect register reset to 1 (level-high frame_start out of reset is not an edge).
- Write latency: wen_lut/waddr_lut/wdata_lut registered, asserted the cycle after the accepting handshake; one write per cycle sustained.
- det_ready combinational from state only (no dependency on det_valid).
- bad_point_num updates on the clk edge that leaves COMMIT, i.e. 2 cycles after frame_end.
- busy = (state != IDLE).
- Reset mid-frame: returns to IDLE, bad_point_num 0; partial table abandoned.

## Configuration
- BAD_POINT_LUT_PINGPONG_EN defined: waddr_lut is BAD_POINT_BIT+1 bits, MSB = write bank = ~bank_sel; extra output bank_sel (1 bit, reset 0) toggles with bad_point_num update in COMMIT; reader keeps using the old bank and count during collection.
- Undefined: single bank, waddr_lut BAD_POINT_BIT bits, no bank_sel; bad_point_num forced to 0 on entering COLLECT so the reader disables correction while the table is rewritten.

## Structure
- Shared package: state encoding, packed entry layout constants (X field [15:0], Y field [31:16]), CAP derivation.
- One sub-module: bad_point_order_filter (last-key register and strict-greater compare) producing accept/drop_order; capacity and FSM stay in top.

## Test plan
- Frame with (2,1),(5,1),(0,3) then frame_end → writes addr 0,1,2 data 0x00010002, 0x00010005, 0x00030000; bad_point_num=3 two cycles after frame_end.
- (5,1) then (5,1) then (4,1) → one write; order_err=1; bad_point_num=1.
- 130 strictly increasing coordinates, BAD_POINT_NUM=128 → 127 writes, overflow=1, bad_point_num=127.
- Handshake coincident with frame_end → entry written and counted.
- frame_start edge and frame_end same cycle in COLLECT → restart, bad_point_num unchanged, flags cleared.
- rst_n low mid-COLLECT → all outputs 0, det_ready 0; with macro, two frames → waddr MSB alternates 1,0 and bank_sel toggles each commit.

Source files
------------

// File: rtl/bad_point_lut_writer_pkg.sv
// bad_point_lut_writer_pkg: shared definitions for the bad-point LUT writer.
//   state_e     : writer FSM states (IDLE, COLLECT, COMMIT)
//   X_/Y_ field : packed 32-bit LUT entry layout, X in [15:0], Y in [31:16]
//   cap_of()    : usable table capacity, one slot less than the BRAM depth
package bad_point_lut_writer_pkg;
   typedef enum logic [1:0] {IDLE, COLLECT, COMMIT} state_e;
   localparam int X_LSB = 0;
   localparam int X_MSB = 15;
   localparam int Y_LSB = 16;
   localparam int Y_MSB = 31;
   function automatic int cap_of(input int num);
      return num - 1;
   endfunction
endpackage

// File: rtl/bad_point_lut_writer_if.sv
// bad_point_lut_writer_if: frame control, detector handshake, LUT write port
// and status of the bad-point LUT writer.
//   frame_start/frame_end      : collection control (master -> writer)
//   det_valid/det_x/det_y      : detected coordinate (master -> writer)
//   det_ready                  : writer accepts coordinate
//   wen_lut/waddr_lut/wdata_lut: BRAM write port
//   bad_point_num              : committed entry count for the reader
//   busy/overflow/order_err    : status
//   bank_sel                   : read bank, only with BAD_POINT_LUT_PINGPONG_EN
// Modports: master (frame/detector source), slave (the writer).
interface bad_point_lut_writer_if #(
   parameter int WIDTH_BITS    = 10,
   parameter int HEIGHT_BITS   = 10,
   parameter int BAD_POINT_BIT = 7
);
`ifdef BAD_POINT_LUT_PINGPONG_EN
   localparam int AW = BAD_POINT_BIT + 1;
   logic bank_sel;
`else
   localparam int AW = BAD_POINT_BIT;
`endif
   logic                     frame_start;
   logic                     frame_end;
   logic                     det_valid;
   logic                     det_ready;
   logic [WIDTH_BITS-1:0]    det_x;
   logic [HEIGHT_BITS-1:0]   det_y;
   logic                     wen_lut;
   logic [AW-1:0]            waddr_lut;
   logic [31:0]              wdata_lut;
   logic [BAD_POINT_BIT-1:0] bad_point_num;
   logic                     busy;
   logic                     overflow;
   logic                     order_err;
`ifdef BAD_POINT_LUT_PINGPONG_EN
   modport master (output frame_start, frame_end, det_valid, det_x, det_y,
                   input det_ready, wen_lut, waddr_lut, wdata_lut, bad_point_num,
                   busy, overflow, order_err, bank_sel);
   modport slave  (input frame_start, frame_end, det_valid, det_x, det_y,
                   output det_ready, wen_lut, waddr_lut, wdata_lut, bad_point_num,
                   busy, overflow, order_err, bank_sel);
`else
   modport master (output frame_start, frame_end, det_valid, det_x, det_y,
                   input det_ready, wen_lut, waddr_lut, wdata_lut, bad_point_num,
                   busy, overflow, order_err);
   modport slave  (input frame_start, frame_end, det_valid, det_x, det_y,
                   output det_ready, wen_lut, waddr_lut, wdata_lut, bad_point_num,
                   busy, overflow, order_err);
`endif
endinterface

// File: rtl/bad_point_lut_writer_order_filter.sv
// bad_point_order_filter: keeps the last written raster key and flags
// handshakes whose key is not strictly greater.
//   clk, rst_n    : clock, async active-low reset
//   clr_i         : forget the last key (new collection)
//   hs_i, key_i   : handshake and its {y, x} key
//   upd_i         : key was written, remember it
//   accept_o      : handshake in raster order
//   drop_order_o  : handshake is a duplicate or out of order
module bad_point_order_filter #(
   parameter int KEY_BITS = 20
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                clr_i,
   input  logic                hs_i,
   input  logic                upd_i,
   input  logic [KEY_BITS-1:0] key_i,
   output logic                accept_o,
   output logic                drop_order_o
);
   logic [KEY_BITS-1:0] last_q;
   logic                vld_q;
   logic                ok;
   assign ok           = ~vld_q | (key_i > last_q);
   assign accept_o     = hs_i & ok;
   assign drop_order_o = hs_i & ~ok;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q <= '0;
         vld_q  <= 1'b0;
      end else if (clr_i) begin
         vld_q  <= 1'b0;
      end else if (upd_i) begin
         last_q <= key_i;
         vld_q  <= 1'b1;
      end
   end
endmodule

// File: rtl/bad_point_lut_writer.sv
// bad_point_lut_writer: collects detector coordinates in strict raster order
// into the bad-point BRAM and publishes the committed count at frame end.
//   clk, rst_n : clock (also LUT write clock), async active-low reset
//   bus        : bad_point_lut_writer_if.slave (frame control, detector
//                handshake, LUT write port, count and status)
// Optional: BAD_POINT_LUT_PINGPONG_EN selects a double-buffered table; the
// write bank is ~bank_sel and bank_sel flips when a count is committed.
module bad_point_lut_writer
   import bad_point_lut_writer_pkg::*;
#(
   parameter int WIDTH_BITS    = 10,
   parameter int HEIGHT_BITS   = 10,
   parameter int BAD_POINT_NUM = 128,
   parameter int BAD_POINT_BIT = 7
) (
   input logic                  clk,
   input logic                  rst_n,
   bad_point_lut_writer_if.slave bus
);
   localparam logic [BAD_POINT_BIT-1:0] CAP = BAD_POINT_BIT'(cap_of(BAD_POINT_NUM));
   state_e                   state_q;
   logic                     fs_q;
   logic [BAD_POINT_BIT-1:0] cnt_q;
   logic                     fs_edge_d;
   logic                     hs_d;
   logic                     accept;
   logic                     drop_order;
   logic                     full_d;
   logic                     wr_d;
   assign fs_edge_d     = bus.frame_start & ~fs_q;
   assign hs_d          = bus.det_valid & bus.det_ready;
   assign full_d        = cnt_q == CAP;
   // a restart edge discards whatever handshake shares its cycle
   assign wr_d          = accept & ~full_d & ~fs_edge_d;
   assign bus.det_ready = state_q == COLLECT;
   assign bus.busy      = state_q != IDLE;
   bad_point_order_filter #(.KEY_BITS(WIDTH_BITS + HEIGHT_BITS)) u_filter (
      .clk          (clk),
      .rst_n        (rst_n),
      .clr_i        (fs_edge_d),
      .hs_i         (hs_d),
      .upd_i        (wr_d),
      .key_i        ({bus.det_y, bus.det_x}),
      .accept_o     (accept),
      .drop_order_o (drop_order)
   );
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q           <= IDLE;
         fs_q              <= 1'b1;
         cnt_q             <= '0;
         bus.wen_lut       <= 1'b0;
         bus.waddr_lut     <= '0;
         bus.wdata_lut     <= '0;
         bus.bad_point_num <= '0;
         bus.overflow      <= 1'b0;
         bus.order_err     <= 1'b0;
`ifdef BAD_POINT_LUT_PINGPONG_EN
         bus.bank_sel      <= 1'b0;
`endif
      end else begin
         fs_q        <= bus.frame_start;
         bus.wen_lut <= wr_d;
         if (wr_d) begin
`ifdef BAD_POINT_LUT_PINGPONG_EN
            bus.waddr_lut <= {~bus.bank_sel, cnt_q};
`else
            bus.waddr_lut <= cnt_q;
`endif
            bus.wdata_lut[X_MSB:X_LSB] <= 16'(bus.det_x);
            bus.wdata_lut[Y_MSB:Y_LSB] <= 16'(bus.det_y);
         end
         if (fs_edge_d) begin
            state_q       <= COLLECT;
            cnt_q         <= '0;
            bus.overflow  <= 1'b0;
            bus.order_err <= 1'b0;
`ifndef BAD_POINT_LUT_PINGPONG_EN
            // single bank: reader must stop correcting while the table is rewritten
            bus.bad_point_num <= '0;
`endif
         end else begin
            case (state_q)
               COLLECT: begin
                  if (drop_order) bus.order_err <= 1'b1;
                  if (accept & full_d) bus.overflow <= 1'b1;
                  if (wr_d) cnt_q <= cnt_q + 1'b1;
                  if (bus.frame_end) state_q <= COMMIT;
               end
               COMMIT: begin
                  bus.bad_point_num <= cnt_q;
`ifdef BAD_POINT_LUT_PINGPONG_EN
                  bus.bank_sel      <= ~bus.bank_sel;
`endif
                  state_q           <= IDLE;
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_bad_point_lut_writer.sv
// tb_bad_point_lut_writer: directed and randomized frames against a
// transaction-level model of the bad-point LUT writer.
module tb_bad_point_lut_writer;
   localparam int W = 10;
   localparam int H = 10;
   localparam int N = 128;
   localparam int B = 7;
   localparam int CAP = N - 1;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;
   bad_point_lut_writer_if #(.WIDTH_BITS(W), .HEIGHT_BITS(H), .BAD_POINT_BIT(B)) bus ();
   bad_point_lut_writer #(.WIDTH_BITS(W), .HEIGHT_BITS(H), .BAD_POINT_NUM(N), .BAD_POINT_BIT(B)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );
   always #5 clk = ~clk;

   // model: phase 0 idle, 1 collecting, 2 committing
   int          m_phase, m_cnt, m_last, m_bpn, m_key;
   bit          m_lastv, m_ovf, m_oerr, m_bank, m_fs_prev, m_edge;
   bit          e_wen;
   logic [63:0] e_addr, e_data;
   logic [63:0] log_a [256];
   logic [63:0] log_d [256];
   int          log_n = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      if (!rst_n) begin
         m_phase = 0; m_cnt = 0; m_last = 0; m_bpn = 0;
         m_lastv = 0; m_ovf = 0; m_oerr = 0; m_bank = 0; m_fs_prev = 1; e_wen = 0;
      end else begin
         e_wen = 0;
         m_edge = bus.frame_start && !m_fs_prev;
         m_fs_prev = bus.frame_start;
         m_key = int'(bus.det_y) * (1 << W) + int'(bus.det_x);
         if (m_edge) begin
            m_phase = 1; m_cnt = 0; m_ovf = 0; m_oerr = 0; m_lastv = 0;
`ifndef BAD_POINT_LUT_PINGPONG_EN
            m_bpn = 0;
`endif
         end else if (m_phase == 1) begin
            if (bus.det_valid) begin
               if (m_lastv && m_key <= m_last) m_oerr = 1;
               else if (m_cnt == CAP) m_ovf = 1;
               else begin
                  e_wen = 1;
`ifdef BAD_POINT_LUT_PINGPONG_EN
                  e_addr = 64'(m_cnt + (m_bank ? 0 : N));
`else
                  e_addr = 64'(m_cnt);
`endif
                  e_data = 64'(bus.det_y) * 65536 + 64'(bus.det_x);
                  m_cnt++;
                  m_last = m_key;
                  m_lastv = 1;
               end
            end
            if (bus.frame_end) m_phase = 2;
         end else if (m_phase == 2) begin
            m_bpn = m_cnt;
            m_bank = !m_bank;
            m_phase = 0;
         end
      end
   end

   always @(posedge clk) begin
      #1;
      chk("det_ready", 64'(bus.det_ready), 64'(m_phase == 1));
      chk("busy", 64'(bus.busy), 64'(m_phase != 0));
      chk("wen_lut", 64'(bus.wen_lut), 64'(e_wen));
      if (e_wen) begin
         chk("waddr_lut", 64'(bus.waddr_lut), e_addr);
         chk("wdata_lut", 64'(bus.wdata_lut), e_data);
      end
      chk("bad_point_num", 64'(bus.bad_point_num), 64'(m_bpn));
      chk("overflow", 64'(bus.overflow), 64'(m_ovf));
      chk("order_err", 64'(bus.order_err), 64'(m_oerr));
`ifdef BAD_POINT_LUT_PINGPONG_EN
      chk("bank_sel", 64'(bus.bank_sel), 64'(m_bank));
`endif
      if (bus.wen_lut === 1'b1 && log_n < 256) begin
         log_a[log_n] = 64'(bus.waddr_lut);
         log_d[log_n] = 64'(bus.wdata_lut);
         log_n++;
      end
   end

   task automatic step(input bit fs, input bit fe, input bit v, input int x, input int y);
      bus.frame_start = fs;
      bus.frame_end   = fe;
      bus.det_valid   = v;
      bus.det_x       = W'(x);
      bus.det_y       = H'(y);
      @(negedge clk);
   endtask

   task automatic pin_reset_outputs(input string tag);
      chk({tag, " busy"}, 64'(bus.busy), 0);
      chk({tag, " det_ready"}, 64'(bus.det_ready), 0);
      chk({tag, " wen_lut"}, 64'(bus.wen_lut), 0);
      chk({tag, " bad_point_num"}, 64'(bus.bad_point_num), 0);
      chk({tag, " overflow"}, 64'(bus.overflow), 0);
      chk({tag, " order_err"}, 64'(bus.order_err), 0);
   endtask

   initial begin
      int cx, cy, n, r;
      bit v;
      bus.frame_start = 0; bus.frame_end = 0; bus.det_valid = 0; bus.det_x = '0; bus.det_y = '0;
      repeat (3) @(negedge clk);
      pin_reset_outputs("reset");
      rst_n = 1'b1;
      step(0, 0, 0, 0, 0);

      // three raster-ordered points
      step(1, 0, 0, 0, 0);
      log_n = 0;
      step(0, 0, 1, 2, 1);
      step(0, 0, 1, 5, 1);
      step(0, 0, 1, 0, 3);
      step(0, 1, 0, 0, 0);
      chk("t1 bpn before commit", 64'(bus.bad_point_num), 0);
      step(0, 0, 0, 0, 0);
      chk("t1 bpn", 64'(bus.bad_point_num), 3);
      chk("t1 writes", 64'(log_n), 3);
      chk("t1 addr0", log_a[0] & 64'(N - 1), 0);
      chk("t1 addr2", log_a[2] & 64'(N - 1), 2);
      chk("t1 data0", log_d[0], 64'h00010002);
      chk("t1 data1", log_d[1], 64'h00010005);
      chk("t1 data2", log_d[2], 64'h00030000);
`ifdef BAD_POINT_LUT_PINGPONG_EN
      chk("t1 write bank", log_a[0] >> B, 1);
      chk("t1 bank_sel", 64'(bus.bank_sel), 1);
`endif

      // duplicate and backwards keys
      step(1, 0, 0, 0, 0);
      log_n = 0;
      step(0, 0, 1, 5, 1);
      step(0, 0, 1, 5, 1);
      step(0, 0, 1, 4, 1);
      step(0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      chk("t2 writes", 64'(log_n), 1);
      chk("t2 order_err", 64'(bus.order_err), 1);
      chk("t2 bpn", 64'(bus.bad_point_num), 1);
`ifdef BAD_POINT_LUT_PINGPONG_EN
      chk("t2 write bank", log_a[0] >> B, 0);
      chk("t2 bank_sel", 64'(bus.bank_sel), 0);
`endif

      // capacity overflow
      step(1, 0, 0, 0, 0);
      log_n = 0;
      for (int i = 0; i < 130; i++) step(0, 0, 1, i, 0);
      step(0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      chk("t3 writes", 64'(log_n), 127);
      chk("t3 overflow", 64'(bus.overflow), 1);
      chk("t3 bpn", 64'(bus.bad_point_num), 127);

      // handshake together with frame_end
      step(1, 0, 0, 0, 0);
      step(0, 0, 1, 1, 1);
      step(0, 1, 1, 2, 1);
      step(0, 0, 0, 0, 0);
      chk("t4 bpn", 64'(bus.bad_point_num), 2);

      // restart and frame_end in the same cycle
      step(1, 0, 0, 0, 0);
      step(0, 0, 1, 5, 1);
      step(0, 0, 1, 5, 1);
      chk("t5 order_err set", 64'(bus.order_err), 1);
      step(1, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      chk("t5 busy", 64'(bus.busy), 1);
      chk("t5 order_err cleared", 64'(bus.order_err), 0);
      step(0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      chk("t5 bpn", 64'(bus.bad_point_num), 0);

      // reset in the middle of a collection
      step(1, 0, 0, 0, 0);
      step(0, 0, 1, 3, 3);
      step(0, 0, 1, 4, 3);
      rst_n = 1'b0;
      #1;
      pin_reset_outputs("midreset");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      step(0, 0, 0, 0, 0);

      // randomized frames
      for (int f = 0; f < 12; f++) begin
         step(1, 0, 0, 0, 0);
         cx = $urandom_range(0, 10);
         cy = $urandom_range(0, 3);
         n = $urandom_range(0, 40);
         for (int k = 0; k < n; k++) begin
            r = $urandom_range(0, 9);
            if (r == 1 && cx > 0) cx--;
            else if (r > 2) cx += $urandom_range(1, 5);
            if (cx > 1000) begin cx = $urandom_range(0, 3); cy++; end
            v = ($urandom_range(0, 3) != 0);
            step((r == 9 && k[2:0] == 3'd5), 0, v, cx, cy);
            if (r == 9) step(0, 0, 0, 0, 0);
         end
         step(0, 1, $urandom_range(0, 1) == 1, cx + 1, cy);
         step(0, 0, 0, 0, 0);
         if ($urandom_range(0, 2) == 0) step(0, 1, 1, 0, 0);
         repeat ($urandom_range(0, 3)) step(0, 0, 0, 0, 0);
      end
      repeat (3) step(0, 0, 0, 0, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
